// File: rtl/memory_store_writer.sv
// Store-side RAM writer: queues 1/2/4-byte stores and serialises each into
// little-endian single-byte writes on the arbitrated RAM port.
module memory_store_writer #(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter logic [31:0] IO_BASE     = 32'h00030000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_mode,
    output logic        req_ready,
    input  logic        grant,
    input  logic        io_buffer_full,
    output logic        ram_en,
    output logic        ram_wr,
    output logic [31:0] ram_addr,
    output logic [7:0]  ram_dout,
    output logic        done,
    output logic        busy,
    output logic [2:0]  pending
);

    localparam int unsigned PtrW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic {StIdle, StWrite} state_e;

    state_e state_q, state_d;

    logic [31:0] q_addr   [QUEUE_DEPTH];
    logic [31:0] q_data   [QUEUE_DEPTH];
    logic [2:0]  q_nbytes [QUEUE_DEPTH];

    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;

    logic [31:0] cur_addr_q, cur_data_q, data_shift;
    logic [2:0]  cur_nbytes_q;
    logic [1:0]  idx_q, idx_d;

    logic        push, load, stall, in_write;
    logic [2:0]  push_nbytes;
    logic [CntW:0] pending_sum;

    assign req_ready = (count_q < CntW'(QUEUE_DEPTH));
    assign push      = en && req_valid && req_ready;

    always_comb begin
        unique case (req_mode)
            2'd0:    push_nbytes = 3'd1;
            2'd1:    push_nbytes = 3'd2;
            default: push_nbytes = 3'd4;
        endcase
    end

    // Storage needs no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr_q]   <= req_addr;
            q_data[wr_ptr_q]   <= req_data;
            q_nbytes[wr_ptr_q] <= push_nbytes;
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, load})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (load) rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_d;
        end
    end

    // IO-ness is judged on the store's base address, not per byte.
    assign stall      = (cur_addr_q >= IO_BASE) && io_buffer_full;
    assign data_shift = cur_data_q >> {idx_q, 3'b000};

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        load     = 1'b0;
        done     = 1'b0;
        ram_en   = 1'b0;
        ram_addr = 32'h0;
        ram_dout = 8'h0;
        unique case (state_q)
            StIdle: begin
                if (en && (count_q != '0) && grant) begin
                    load    = 1'b1;
                    idx_d   = 2'd0;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                ram_addr = cur_addr_q + {30'b0, idx_q};
                ram_dout = data_shift[7:0];
                if (en && grant && !stall) begin
                    ram_en = 1'b1;
                    if ({1'b0, idx_q} == (cur_nbytes_q - 3'd1)) begin
                        done    = 1'b1;
                        idx_d   = 2'd0;
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign ram_wr = ram_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            idx_q        <= 2'd0;
            cur_addr_q   <= 32'h0;
            cur_data_q   <= 32'h0;
            cur_nbytes_q <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (load) begin
                cur_addr_q   <= q_addr[rd_ptr_q];
                cur_data_q   <= q_data[rd_ptr_q];
                cur_nbytes_q <= q_nbytes[rd_ptr_q];
            end
        end
    end

    assign in_write    = (state_q == StWrite);
    assign pending_sum = {1'b0, count_q} + {{CntW{1'b0}}, in_write};
    assign pending     = (pending_sum > (CntW + 1)'(7)) ? 3'd7 : pending_sum[2:0];
    assign busy        = (pending != 3'd0);

endmodule

// File: doc/memory_store_writer.md
Name: memory_store_writer

Overview:
- Write-side companion to the byte-wide RAM read controller. Accepts 1/2/4-byte store requests from the data cache or store path and buffers them in a small FIFO.
- Serialises each store into consecutive single-byte RAM writes in little-endian order.
- Obeys an external arbiter grant and the IO buffer-full backpressure for memory-mapped IO addresses.
- Sits between the store path and the shared RAM port. The arbiter grants the port to either the read controller or this block.

Parameters:
- QUEUE_DEPTH, 4, store FIFO entries; power of 2, minimum 2.
- IO_BASE, 32'h00030000, addresses >= IO_BASE are memory-mapped IO and are subject to io_buffer_full.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low
- en  input  1  global ready; 0 freezes all state, blocks push, forces ram_en=0
- req_valid  input  1  store request present
- req_addr  input  32  byte address of store
- req_data  input  32  store data; low bytes used per mode
- req_mode  input  2  0=1 byte, 1=2 bytes, 2=4 bytes, 3 treated as 4 bytes
- req_ready  output  1  FIFO can accept; combinational, = (count < QUEUE_DEPTH)
- grant  input  1  arbiter grants RAM port this cycle
- io_buffer_full  input  1  IO sink cannot take a byte this cycle
- ram_en  output  1  RAM access this cycle
- ram_wr  output  1  1=write; equals ram_en
- ram_addr  output  32  byte address of current access
- ram_dout  output  8  byte to write
- done  output  1  one-cycle pulse when the last byte of a store is issued
- busy  output  1  pending != 0
- pending  output  3  FIFO count + (state==WRITE), saturates at 7

Behaviour:
- Reset (rst=0, async):
  - FIFO empty, state IDLE, byte index 0.
  - All outputs 0, except req_ready=1.
- Push rule:
  - Push when en && req_valid && req_ready. Entry = {addr, data, nbytes}, where nbytes is 1/2/4.
  - req_ready uses the count before any same-cycle pop, so a full FIFO never accepts, even while popping.
  - Simultaneous push and pop leaves count unchanged.
- FSM states: IDLE, WRITE.
- IDLE:
  - If en && FIFO non-empty && grant, load the head into working registers (cur_addr, cur_data, nbytes), set idx=0, pop, and go to WRITE.
  - ram_en=0 and ram_addr/ram_dout=0 in IDLE.
- WRITE:
  - Datapath:
    - ram_addr = cur_addr + idx (32-bit modular; 0xFFFFFFFF+1 = 0).
    - ram_dout = cur_data[8*idx+7 : 8*idx].
  - Issue rule:
    - stall = is_io && io_buffer_full, where is_io = (cur_addr >= IO_BASE), evaluated on the base address of the store.
    - ram_en = ram_wr = en && grant && !stall (combinational).
    - On each issued cycle, idx increments.
    - The cycle issuing byte nbytes-1 raises done and returns to IDLE.
  - Pausing:
    - grant low or stall holds idx; no byte is written; resume exactly at idx.
  - Latency: minimum 1 + nbytes cycles from the IDLE load cycle; back-to-back stores cost 1 idle/load cycle each.
- en=0: nothing changes (FIFO, state, idx); ram_en=0, done=0.
- Reset mid-store: in-flight store abandoned (bytes already written remain) and FIFO cleared. Next store after reset behaves normally.
- Ordering: stores complete strictly in FIFO order. No merging or reordering.
- busy stays high until the done cycle of the last queued store.

Test Plan:
- Basic word store:
  - Stimulus: push mode 2, addr 0x100, data 0x11223344, grant=1.
  - Response: load cycle, then ram_en=1 for 4 consecutive cycles writing 0x44@0x100, 0x33@0x101, 0x22@0x102, 0x11@0x103. done on the 0x103 cycle only; busy drops the next cycle.
- FIFO full:
  - Stimulus: grant=0, push 4 stores.
  - Response: pending=4, req_ready=0; a 5th req_valid is not accepted. With grant=1, the four stores drain in push order.
- IO backpressure:
  - Stimulus: byte store 0x41 to 0x30000; io_buffer_full=1 for 3 cycles after load.
  - Response: ram_en=0 for those 3 cycles, then one write 0x41@0x30000 with done. The same case at 0x2FFFF ignores io_buffer_full.
- Grant loss mid-halfword:
  - Stimulus: mode 1, addr 0x200, data 0xBEEF; grant drops after the first byte for 2 cycles.
  - Response: 0xEF@0x200, 2-cycle gap, then 0xBE@0x201 with done.
- Reset mid-store:
  - Stimulus: rst low during byte 2 of a word store with 2 more queued.
  - Response: all outputs 0, pending=0, req_ready=1. After release, a new store writes correctly.
- Wrap and mode 3:
  - Stimulus: mode 1 at 0xFFFFFFFF, data 0xA1B2; then mode 3 at 0x10, data 0x01020304.
  - Response: 0xB2@0xFFFFFFFF, 0xA1@0x00000000; then 4 bytes 0x04..0x01 @0x10..0x13.
